// File: rtl/ps2_scancode_sequencer.sv
// PS/2 set-2 byte stream parser: strips E0/F0/E1 prefixes into single make/break events for the matrix.
// Define PS2_HOTKEY_EN to build Ctrl/Alt tracking and the rst_req/nmi_req hotkey pulse counters.
module ps2_scancode_sequencer #(
    parameter int RESET_LEN = 50000,
    parameter int NMI_LEN   = 64,
    parameter int TIMEOUT   = 2048
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       rx_strb,
    input  logic [7:0] rx_data,
    output logic       strb,
    output logic       make,
    output logic [7:0] code,
    output logic       rst_req,
    output logic       nmi_req
);

    typedef enum logic [2:0] {IDLE, BRK, EXT, EXT_BRK, PAUSE} state_t;

    localparam logic [11:0] IDLE_LAST = 12'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [2:0]  skip, skip_next;
    logic [11:0] idle_cnt, idle_next;
    logic        emit, emit_make, emit_ext, pause_done;

    always_comb begin
        state_next = state;
        skip_next  = skip;
        idle_next  = idle_cnt;
        emit       = 1'b0;
        emit_make  = 1'b0;
        emit_ext   = 1'b0;
        pause_done = 1'b0;

        // A pending prefix is abandoned after TIMEOUT ce cycles without a byte
        if (state == IDLE || rx_strb) begin
            idle_next = '0;
        end else if (idle_cnt == IDLE_LAST) begin
            state_next = IDLE;
            idle_next  = '0;
        end else begin
            idle_next = idle_cnt + 12'd1;
        end

        if (rx_strb) begin
            case (state)
                IDLE: begin
                    case (rx_data)
                        8'hE0: state_next = EXT;
                        8'hF0: state_next = BRK;
                        8'hE1: begin
                            state_next = PAUSE;
                            skip_next  = 3'd7;
                        end
                        8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: begin
                        end
                        default: emit = 1'b1;
                    endcase
                end
                BRK: begin
                    state_next = IDLE;
                    if (!(rx_data inside {8'hE0, 8'hE1, 8'hF0})) begin
                        emit      = 1'b1;
                        emit_make = 1'b1;
                    end
                end
                EXT, EXT_BRK: begin
                    if (rx_data == 8'hF0) begin
                        state_next = EXT_BRK;
                    end else begin
                        state_next = IDLE;
                        // E0 12 / E0 59 are the fake shifts wrapped around extended keys
                        if (rx_data != 8'h12 && rx_data != 8'h59) begin
                            emit      = 1'b1;
                            emit_make = (state == EXT_BRK);
                            emit_ext  = 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (skip == 3'd1) begin
                        state_next = IDLE;
                        pause_done = 1'b1;
                    end else begin
                        skip_next = skip - 3'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            skip     <= '0;
            idle_cnt <= '0;
            strb     <= 1'b0;
            make     <= 1'b1;
            code     <= 8'h00;
        end else if (ce) begin
            state    <= state_next;
            skip     <= skip_next;
            idle_cnt <= idle_next;
            strb     <= emit;
            if (emit) begin
                make <= emit_make;
                code <= rx_data;
            end
        end
    end

`ifdef PS2_HOTKEY_EN
    logic        ctrl, alt;
    logic [15:0] rst_cnt, nmi_cnt;
    logic        rst_trig;

    // Modifier state is sampled before this event updates it; Del itself never touches it
    assign rst_trig = emit && !emit_make &&
                      ((rx_data == 8'h07) ||
                       (emit_ext && rx_data == 8'h71 && ctrl && alt));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctrl    <= 1'b0;
            alt     <= 1'b0;
            rst_cnt <= '0;
            nmi_cnt <= '0;
        end else if (ce) begin
            if (emit && rx_data == 8'h14) ctrl <= !emit_make;
            if (emit && rx_data == 8'h11) alt  <= !emit_make;

            if (rst_trig)             rst_cnt <= 16'(RESET_LEN);
            else if (rst_cnt != '0)   rst_cnt <= rst_cnt - 16'd1;

            if (pause_done)           nmi_cnt <= 16'(NMI_LEN);
            else if (nmi_cnt != '0)   nmi_cnt <= nmi_cnt - 16'd1;
        end
    end

    assign rst_req = (rst_cnt != '0);
    assign nmi_req = (nmi_cnt != '0);
`else
    logic unused_hotkey;
    assign unused_hotkey = ^{pause_done, emit_ext, 16'(RESET_LEN), 16'(NMI_LEN)};
    assign rst_req = 1'b0;
    assign nmi_req = 1'b0;
`endif

endmodule
